// File: rtl/borrow_skip_sub_32_pkg.sv
// Shared constants and FSM state type for the borrow-skip subtractor.
// The operand and slice widths are fixed; the slice count and index width follow from them.
package bskip_sub_pkg;
    localparam int WIDTH      = 32;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bskip_state_t;
endpackage

// File: rtl/borrow_skip_sub_32_if.sv
// Handshake and data bundle for borrow_skip_sub_32.
//   master : drives in_valid, a, b, out_ready; sees in_ready and the results
//   slave  : the subtractor side
// The skip_cnt signal exists only when BSKIP_STATS_EN is defined.
interface borrow_skip_sub_32_if;
    import bskip_sub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ovf;
`ifdef BSKIP_STATS_EN
    logic [3:0]       skip_cnt;
`endif

    modport master (
        output in_valid, a, b, out_ready,
`ifdef BSKIP_STATS_EN
        input  skip_cnt,
`endif
        input  in_ready, out_valid, diff, borrow, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef BSKIP_STATS_EN
        output skip_cnt,
`endif
        output in_ready, out_valid, diff, borrow, zero, ovf
    );
endinterface

// File: rtl/borrow_skip_sub_32_slice.sv
// bskip_slice_4: combinational 4-bit ripple slice with a carry-skip bypass.
//   a, bn : minuend slice and inverted subtrahend slice
//   cin   : incoming carry
//   s     : slice sum
//   cout  : outgoing carry (cin when the whole slice propagates)
//   skip  : all four propagate bits set, so the bypass was used
module bskip_slice_4 (
    input  logic [3:0] a,
    input  logic [3:0] bn,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       skip
);
    logic [3:0] p, g;
    logic [4:0] c;

    assign p = a ^ bn;
    assign g = a & bn;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = p[i] ^ c[i];
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    // When every bit propagates, the carry-out is the carry-in, so take the short path.
    assign skip = &p;
    assign cout = skip ? cin : c[4];
endmodule

// File: rtl/borrow_skip_sub_32.sv
// borrow_skip_sub_32: multi-cycle subtractor computing a - b as a + ~b + 1,
// one 4-bit carry-skip slice per clock, one operation in flight.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of borrow_skip_sub_32_if (operands in, diff/borrow/zero/ovf out)
// Optional: BSKIP_STATS_EN adds skip_cnt, the number of slices that took the skip path.
module borrow_skip_sub_32
    import bskip_sub_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    borrow_skip_sub_32_if.slave bus
);
    bskip_state_t     state;
    logic [WIDTH-1:0] a_r, bn_r, diff_r, diff_nx;
    logic [IDX_W-1:0] idx;
    logic [4:0]       lsb;
    logic             carry, in_ready_r, out_valid_r, borrow_r, zero_r, ovf_r;
    logic [3:0]       s;
    logic             cout, skip;
    logic             last;

    assign lsb  = {idx, 2'b00};
    assign last = (idx == IDX_W'(NUM_SLICES - 1));

    // Single slice reused every cycle; the index selects which nibble it sees.
    bskip_slice_4 u_slice (
        .a    (a_r[lsb +: SLICE_W]),
        .bn   (bn_r[lsb +: SLICE_W]),
        .cin  (carry),
        .s    (s),
        .cout (cout),
        .skip (skip)
    );

    // Result word with the current slice merged in, so zero/ovf see the final value on the last slice.
    always_comb begin
        diff_nx                = diff_r;
        diff_nx[lsb +: SLICE_W] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= '0;
            bn_r        <= '0;
            diff_r      <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            borrow_r    <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r        <= bus.a;
                    bn_r       <= ~bus.b;
                    carry      <= 1'b1;    // the +1 of two's-complement negation
                    idx        <= '0;
                    diff_r     <= '0;
                    in_ready_r <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    diff_r <= diff_nx;
                    carry  <= cout;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        borrow_r    <= ~cout;
                        zero_r      <= (diff_nx == '0);
                        // bn_r holds ~b, so equal top bits means the operand signs differ.
                        ovf_r       <= (a_r[WIDTH-1] == bn_r[WIDTH-1]) &&
                                       (diff_nx[WIDTH-1] != a_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.borrow    = borrow_r;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;

`ifdef BSKIP_STATS_EN
    logic [3:0] skip_cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip_cnt_r <= '0;
        else if (state == IDLE && bus.in_valid)
            skip_cnt_r <= '0;
        else if (state == RUN && skip)
            skip_cnt_r <= skip_cnt_r + 1'b1;
    end

    assign bus.skip_cnt = skip_cnt_r;
`endif
endmodule
